// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the divider sequencer.
//   W_DEF    default operand / quotient / remainder width
//   ITER_DEF default number of divider step cycles after the load edge
//   DZ_QUOT  quotient reported for a divide-by-zero (all ones)
//   state_e  sequencer states
package div_pkg;

  localparam int W_DEF    = 4;
  localparam int ITER_DEF = 4;

  localparam logic [W_DEF-1:0] DZ_QUOT = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_CAP,
    S_HOLD
  } state_e;

endpackage

// File: rtl/div_seq_stat.sv
// div_seq_stat: saturating completion counters for the divider sequencer.
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   take_i     a valid result is being acknowledged this cycle
//   take_dz_i  the result being acknowledged is a divide-by-zero
//   n_done_o   number of results taken (saturates at all ones)
//   n_dz_o     number of divide-by-zero results taken (saturates at all ones)
module div_seq_stat (
  input  logic        clk,
  input  logic        rst,
  input  logic        take_i,
  input  logic        take_dz_i,
  output logic [15:0] n_done_o,
  output logic [7:0]  n_dz_o
);

  logic [15:0] n_done_q;
  logic [7:0]  n_dz_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_done_q <= '0;
      n_dz_q   <= '0;
    end else if (take_i) begin
      if (n_done_q != '1) n_done_q <= n_done_q + 16'd1;
      if (take_dz_i && (n_dz_q != '1)) n_dz_q <= n_dz_q + 8'd1;
    end
  end

  assign n_done_o = n_done_q;
  assign n_dz_o   = n_dz_q;

endmodule

// File: rtl/div_seq.sv
// div_seq: sequencer sitting in front of a W-bit shift-subtract divider.
// Accepts an operand pair (start/busy), pulses the divider load for one
// cycle, waits ITER divider steps, captures quotient/remainder and offers
// them on a valid/ack handshake. A zero divisor never starts the divider;
// it produces q=all ones, r=dividend, dz=1 one edge after acceptance.
// Optional feature macro: DIV_SEQ_STAT_EN adds saturating counters
// n_done (results taken) and n_dz (divide-by-zero results taken).
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   start, a_in, b_in  request and operands, taken when busy=0
//   busy               high from acceptance until the result is acked
//   ld, a, b           divider load pulse and latched operands
//   ry, ra             divider quotient / remainder registers
//   q, r, valid, dz    captured result and its flags
//   ack                consumer takes the result while valid=1
//   n_done, n_dz       statistics (DIV_SEQ_STAT_EN only)
module div_seq
  import div_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int ITER = ITER_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a_in,
  input  logic [W-1:0]   b_in,
  output logic           busy,
  output logic           ld,
  output logic [W-1:0]   a,
  output logic [W-1:0]   b,
  input  logic [W-1:0]   ry,
  input  logic [2*W-1:0] ra,
  output logic [W-1:0]   q,
  output logic [W-1:0]   r,
  output logic           valid,
  output logic           dz,
  input  logic           ack
`ifdef DIV_SEQ_STAT_EN
  ,
  output logic [15:0]    n_done,
  output logic [7:0]     n_dz
`endif
);

  localparam int CNT_W = $clog2(ITER + 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             ld_q;
  logic             valid_q;
  logic             dz_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     q_q;
  logic [W-1:0]     r_q;

  logic             take_d;
  logic             accept_d;

  // The remainder never exceeds the divisor, so only the low half of ra
  // carries information.
  logic unused_ra_hi;
  assign unused_ra_hi = ^ra[2*W-1:W];

  // A result is consumed only while it is actually on offer.
  assign take_d   = (state_q == S_HOLD) && valid_q && ack;
  // New work is taken from IDLE, or in the same edge a held result is acked.
  assign accept_d = start && ((state_q == S_IDLE) || take_d);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ld_q    <= 1'b0;
      valid_q <= 1'b0;
      dz_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
    end else begin
      ld_q <= 1'b0;

      unique case (state_q)
        S_IDLE: ;
        S_LOAD: begin
          cnt_q   <= '0;
          state_q <= S_RUN;
        end
        S_RUN: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(ITER - 1)) state_q <= S_CAP;
        end
        S_CAP: begin
          q_q     <= ry;
          r_q     <= ra[W-1:0];
          dz_q    <= 1'b0;
          valid_q <= 1'b1;
          state_q <= S_HOLD;
        end
        S_HOLD: begin
          if (take_d) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // Acceptance overrides the HOLD->IDLE exit above for back-to-back work.
      if (accept_d) begin
        a_q    <= a_in;
        b_q    <= b_in;
        busy_q <= 1'b1;
        if (b_in != '0) begin
          ld_q    <= 1'b1;
          state_q <= S_LOAD;
        end else begin
          q_q     <= {W{DZ_QUOT[0]}};
          r_q     <= a_in;
          dz_q    <= 1'b1;
          valid_q <= 1'b1;
          state_q <= S_HOLD;
        end
      end
    end
  end

  assign busy  = busy_q;
  assign ld    = ld_q;
  assign a     = a_q;
  assign b     = b_q;
  assign q     = q_q;
  assign r     = r_q;
  assign valid = valid_q;
  assign dz    = dz_q;

`ifdef DIV_SEQ_STAT_EN
  div_seq_stat u_stat (
    .clk       (clk),
    .rst       (rst),
    .take_i    (take_d),
    .take_dz_i (dz_q),
    .n_done_o  (n_done),
    .n_dz_o    (n_dz)
  );
`endif

endmodule

// File: tb/tb_div_seq.sv
// Testbench for div_seq with a behavioural shift-subtract divider attached.
// Expected results come from plain integer division; latency and load-pulse
// counts come from the handshake rules.
module tb_div_seq;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic           ack = 1'b0;
  logic [W-1:0]   a_in = '0;
  logic [W-1:0]   b_in = '0;
  logic           busy, ld, valid, dz;
  logic [W-1:0]   a, b, q, r;
  logic [W-1:0]   ry;
  logic [2*W-1:0] ra;
`ifdef DIV_SEQ_STAT_EN
  logic [15:0]    n_done;
  logic [7:0]     n_dz;
`endif

  int checks = 0;
  int errors = 0;
  int exp_done = 0;
  int exp_dz = 0;
  logic last_dz = 1'b0;

  always #5 clk = ~clk;

  div_seq #(.W(W), .ITER(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .busy  (busy),
    .ld    (ld),
    .a     (a),
    .b     (b),
    .ry    (ry),
    .ra    (ra),
    .q     (q),
    .r     (r),
    .valid (valid),
    .dz    (dz),
    .ack   (ack)
`ifdef DIV_SEQ_STAT_EN
    ,
    .n_done(n_done),
    .n_dz  (n_dz)
`endif
  );

  // Divider environment: restoring division, one quotient bit per edge,
  // W edges after the load edge. No reset, as in the real divider.
  logic [2*W-1:0] dv_d;
  int             dv_n = W;
  always @(posedge clk) begin
    if (ld) begin
      ra   <= {{W{1'b0}}, a};
      dv_d <= {{W{1'b0}}, b} << (W - 1);
      ry   <= '0;
      dv_n <= 0;
    end else if (dv_n < W) begin
      if (ra >= dv_d) begin
        ra <= ra - dv_d;
        ry <= {ry[W-2:0], 1'b1};
      end else begin
        ry <= {ry[W-2:0], 1'b0};
      end
      dv_d <= dv_d >> 1;
      dv_n <= dv_n + 1;
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int av, input int bv);
    start = 1'b1;
    a_in  = W'(av);
    b_in  = W'(bv);
  endtask

  // Waits (bounded) for valid, then checks latency, load pulses and result.
  task automatic wait_result(input int av, input int bv, input int edges0, input int lds0);
    int edges = edges0;
    int lds = lds0;
    int busy_low = 0;
    bit isdz = (bv == 0);
    while (!(edges > 0 && valid) && edges < 20) begin
      step();
      start = 1'b0;
      edges++;
      lds += int'(ld);
      if (!busy) busy_low++;
    end
    chk("edges_to_valid", edges, isdz ? 1 : 7);
    chk("ld_pulses", lds, isdz ? 0 : 1);
    chk("busy_low_while_running", busy_low, 0);
    chk("q", q, isdz ? (2**W - 1) : (av / bv));
    chk("r", r, isdz ? av : (av % bv));
    chk("dz", dz, isdz);
    chk("a_latched", a, av);
    chk("b_latched", b, bv);
    last_dz = isdz;
  endtask

  task automatic take();
    ack = 1'b1;
    step();
    ack = 1'b0;
    exp_done++;
    if (last_dz) exp_dz++;
    chk("valid_after_ack", valid, 0);
    chk("busy_after_ack", busy, 0);
  endtask

  task automatic do_op(input int av, input int bv, input int hold);
    launch(av, bv);
    wait_result(av, bv, 0, 0);
    repeat (hold) step();
    take();
  endtask

  initial begin
    int ra_v, rb_v;
    logic [W-1:0] q_hold, r_hold;

    // Reset state
    repeat (3) step();
    chk("reset_outputs", {busy, ld, valid, dz, q, r, a, b}, 0);
    rst = 1'b1;
    step();

    // Basic divisions, including divide-by-zero
    do_op(13, 3, 0);
    do_op(9, 0, 1);
    do_op(15, 1, 0);
    do_op(2, 7, 2);

    // ack without a result is ignored
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("idle_ack_valid", valid, 0);
    chk("idle_ack_busy", busy, 0);

    // Long hold: result stable, extra start requests ignored
    launch(11, 4);
    wait_result(11, 4, 0, 0);
    q_hold = q;
    r_hold = r;
    for (int i = 0; i < 10; i++) begin
      start = i[0];
      a_in  = W'($urandom);
      b_in  = W'($urandom);
      step();
      chk("hold_qr", {q, r}, {q_hold, r_hold});
      chk("hold_flags", {valid, busy, ld, a, b}, {1'b1, 1'b1, 1'b0, 4'd11, 4'd4});
    end
    start = 1'b0;

    // Back-to-back: ack with a new start in the same cycle
    ack = 1'b1;
    launch(8, 2);
    step();
    ack = 1'b0;
    start = 1'b0;
    exp_done++;
    chk("b2b_valid_drop", valid, 0);
    chk("b2b_busy", busy, 1);
    chk("b2b_ld", ld, 1);
    wait_result(8, 2, 1, int'(ld));
    take();

    // Reset in the middle of RUN
    launch(13, 3);
    repeat (3) begin
      step();
      start = 1'b0;
    end
    rst = 1'b0;
    #1;
    chk("midrun_reset_outputs", {busy, ld, valid, dz, q, r, a, b}, 0);
    exp_done = 0;
    exp_dz = 0;
    #2;
    rst = 1'b1;
    do_op(7, 2, 0);

    // Randomised operand pairs with random ack delays
    for (int i = 0; i < 24; i++) begin
      ra_v = int'($urandom_range(0, 2**W - 1));
      rb_v = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 2**W - 1));
      do_op(ra_v, rb_v, int'($urandom_range(0, 3)));
    end

`ifdef DIV_SEQ_STAT_EN
    chk("n_done", n_done, exp_done);
    chk("n_dz", n_dz, exp_dz);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
